pcie_rx_deframer: RTL
=====================

Name: pcie_rx_deframer

Overview:
- Sits directly downstream of the symbol-select stage and consumes its 8-bit symbol/byte stream, one byte per CLK_2MHz cycle.
- Recognises framing symbols and extracts packet payload bytes into a framed data stream.
- Detects SKP ordered sets and flags protocol errors.
- Feeds the link-layer receive logic.

Parameters:
- MAX_LEN, 32: maximum payload bytes per packet; longer packets are errors.
- SKP_N, 3: number of SKP symbols after COM that complete a SKP ordered set.
- LEN_W, 6: width of the payload length counter; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- CLK_2MHz  in  1  block clock.
- reset  in  1  asynchronous, active-low reset. One clock; no other reset.
- ENB  in  1  enable. When low, the FSM and counters hold and all pulse outputs are 0.
- DATA_IN  in  8  symbol or byte from the upstream selector.
- PKT_DATA  out  8  payload byte.
- PKT_VALID  out  1  PKT_DATA is valid this cycle.
- PKT_SOP  out  1  asserted with the first payload byte of a packet.
- PKT_TYPE  out  1  0 = TLP (STP-started), 1 = DLLP (SDP-started); held for the packet.
- PKT_DONE  out  1  one-cycle pulse: packet closed by END.
- PKT_ABORT  out  1  one-cycle pulse: packet closed by EDB.
- PKT_LEN  out  LEN_W  payload byte count; valid while PKT_DONE is high.
- SKP_OS  out  1  one-cycle pulse: COM followed by SKP_N SKPs.
- ERR  out  1  one-cycle pulse: protocol violation.

Behaviour:
- Symbol codes:
  - COM = BC, PAD = C7, SKP = AC, STP = AA, SDP = E5, END = F6, EDB = DF, FTS = A8, IDL = AE.
  - Any other value is a data byte; FF is a normal data byte.
- Timing: all outputs are registered. The response to DATA_IN sampled at edge n appears after edge n. Latency is 1 cycle.
- Reset: every output is 0, state is IDLE, length and SKP counters are 0. This applies immediately on reset low, including mid-packet; no DONE or ABORT is emitted for the interrupted packet.
- FSM has three states: IDLE, PKT, SKPCHK.
- IDLE:
  - STP: go to PKT, len = 0, PKT_TYPE = 0.
  - SDP: go to PKT, len = 0, PKT_TYPE = 1.
  - COM: go to SKPCHK, skp count = 0.
  - END or EDB: ERR pulse, stay in IDLE.
  - Data, PAD, IDL, FTS, SKP: ignored.
- PKT:
  - Data byte: PKT_VALID = 1 and PKT_DATA = byte. PKT_SOP = 1 if len == 0. Then len++.
  - len == MAX_LEN and another data byte arrives: ERR pulse, packet dropped (no DONE), go to IDLE.
  - END with len > 0: PKT_DONE = 1, PKT_LEN = len, go to IDLE.
  - END with len == 0: ERR pulse, go to IDLE.
  - EDB: PKT_ABORT = 1, go to IDLE (any len).
  - STP or SDP: ERR pulse, then restart a new packet in the same cycle (len = 0, new PKT_TYPE).
  - COM, PAD, IDL, FTS, SKP: ERR pulse, go to IDLE.
- SKPCHK:
  - SKP: count++. When count reaches SKP_N: SKP_OS pulse, go to IDLE.
  - Any other byte: go to IDLE with no ERR, and the byte is evaluated with IDLE rules in the same cycle. Example: COM then STP starts a packet.
  - Second COM: restarts the count at 0.
- ENB low: holds the cycle completely, and DATA_IN is ignored.
- Simultaneous pulses: ERR may coincide only with the restart case. DONE and ABORT are mutually exclusive.

Optional Feature:
- PCIE_DEFRAMER_STATS_EN defined:
  - Adds outputs PKT_CNT[15:0] (incremented on PKT_DONE), ABORT_CNT[15:0] and ERR_CNT[15:0].
  - All counters saturate at FFFF and reset to 0.
- Undefined: the ports and counters do not exist.

Decomposition:
- Shared package pcie_sym_pkg:
  - symbol code localparams (COM…IDL);
  - FSM state enum encoding;
  - an is_symbol function returning true for the nine codes.
- One sub-module, pcie_skp_counter: counts SKPs after COM and flags completion at SKP_N.

Test Plan:
- Packet: STP, 11, 22, 33, END -> PKT_VALID for 3 cycles with data 11/22/33, SOP on 11; PKT_DONE with PKT_LEN = 3 and PKT_TYPE = 0, one cycle after END.
- SKP set: COM, SKP, SKP, SKP -> one SKP_OS pulse, no ERR. COM, SKP, STP, 44, END -> no SKP_OS, then a DLLP-free TLP of length 1 with PKT_TYPE = 0.
- Abort: SDP, FF, FF, EDB -> two valid bytes, PKT_TYPE = 1, PKT_ABORT pulse, no PKT_DONE.
- Errors: STP, END -> ERR with no DONE. IDLE END -> ERR. STP, 01, STP, 02, END -> ERR at the second STP, then DONE with PKT_LEN = 1.
- Overflow at MAX_LEN = 32: STP plus 33 data bytes -> 32 valid bytes, then ERR; a following END gives ERR and no DONE.
- Reset and ENB: reset low after STP, 11 -> outputs 0 immediately, no DONE after release. ENB low for 4 cycles mid-packet -> no outputs during the hold, and the packet resumes correctly after ENB returns high.

Source files
------------

// File: rtl/pcie_sym_pkg.sv
// Shared symbol codes, deframer state encoding and symbol classification
// for the PCIe receive deframer.
package pcie_sym_pkg;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] PAD = 8'hC7;
  localparam logic [7:0] SKP = 8'hAC;
  localparam logic [7:0] STP = 8'hAA;
  localparam logic [7:0] SDP = 8'hE5;
  localparam logic [7:0] END = 8'hF6;
  localparam logic [7:0] EDB = 8'hDF;
  localparam logic [7:0] FTS = 8'hA8;
  localparam logic [7:0] IDL = 8'hAE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PKT    = 2'd1,
    ST_SKPCHK = 2'd2
  } state_t;

  function automatic logic is_symbol(input logic [7:0] b);
    logic r;
    case (b)
      COM, PAD, SKP, STP, SDP, END, EDB, FTS, IDL: r = 1'b1;
      default:                                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pcie_skp_counter.sv
// Counts SKP symbols following a COM; done is a combinational strobe on the
// SKP that completes the ordered set, and the count clears itself there.
module pcie_skp_counter #(
  parameter int SKP_N = 3
) (
  input  logic CLK_2MHz,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam int CNT_W = $clog2(SKP_N + 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;

  assign cnt_inc_s = cnt_r + CNT_W'(1);
  assign done      = inc && (cnt_inc_s == CNT_W'(SKP_N));

  // SKP count register
  always_ff @(posedge CLK_2MHz or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clr || done) begin
      cnt_r <= '0;
    end else if (inc) begin
      cnt_r <= cnt_inc_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/pcie_rx_deframer.sv
// PCIe receive deframer: extracts STP/SDP framed payload, detects SKP ordered
// sets and flags framing errors. Define PCIE_DEFRAMER_STATS_EN for counters.
module pcie_rx_deframer
  import pcie_sym_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int SKP_N   = 3,
  parameter int LEN_W   = 6
) (
  input  logic             CLK_2MHz,
  input  logic             reset,
  input  logic             ENB,
  input  logic [7:0]       DATA_IN,
  output logic [7:0]       PKT_DATA,
  output logic             PKT_VALID,
  output logic             PKT_SOP,
  output logic             PKT_TYPE,
  output logic             PKT_DONE,
  output logic             PKT_ABORT,
  output logic [LEN_W-1:0] PKT_LEN,
  output logic             SKP_OS,
  output logic             ERR
`ifdef PCIE_DEFRAMER_STATS_EN
  ,
  output logic [15:0]      PKT_CNT,
  output logic [15:0]      ABORT_CNT,
  output logic [15:0]      ERR_CNT
`endif
);

  state_t           state_r, state_nx;
  logic [LEN_W-1:0] len_r, len_nx;
  logic             type_r, type_nx;
  logic [7:0]       data_r, data_nx;
  logic             valid_r, valid_nx;
  logic             sop_r, sop_nx;
  logic             done_r, done_nx;
  logic             abort_r, abort_nx;
  logic [LEN_W-1:0] len_out_r, len_out_nx;
  logic             skp_os_r, skp_os_nx;
  logic             err_r, err_nx;
  logic             skp_clr_s, skp_inc_s, skp_done_s;
  logic             idle_eval_s;

  pcie_skp_counter #(.SKP_N(SKP_N)) u_skp (
    .CLK_2MHz (CLK_2MHz),
    .reset    (reset),
    .clr      (skp_clr_s),
    .inc      (skp_inc_s),
    .done     (skp_done_s)
  );

  // Next-state and next-output decode
  always_comb begin
    state_nx    = state_r;
    len_nx      = len_r;
    type_nx     = type_r;
    data_nx     = data_r;
    valid_nx    = 1'b0;
    sop_nx      = 1'b0;
    done_nx     = 1'b0;
    abort_nx    = 1'b0;
    len_out_nx  = '0;
    skp_os_nx   = 1'b0;
    err_nx      = 1'b0;
    skp_clr_s   = 1'b0;
    skp_inc_s   = 1'b0;
    idle_eval_s = 1'b0;

    if (ENB) begin
      case (state_r)
        ST_IDLE: idle_eval_s = 1'b1;
        ST_PKT: begin
          if (!is_symbol(DATA_IN)) begin
            if (len_r == LEN_W'(MAX_LEN)) begin
              err_nx   = 1'b1;
              state_nx = ST_IDLE;
            end else begin
              valid_nx = 1'b1;
              data_nx  = DATA_IN;
              sop_nx   = (len_r == '0);
              len_nx   = len_r + LEN_W'(1);
            end
          end else begin
            case (DATA_IN)
              END: begin
                if (len_r != '0) begin
                  done_nx    = 1'b1;
                  len_out_nx = len_r;
                end else begin
                  err_nx = 1'b1;
                end
                state_nx = ST_IDLE;
              end
              EDB: begin
                abort_nx = 1'b1;
                state_nx = ST_IDLE;
              end
              STP, SDP: begin
                err_nx  = 1'b1;
                len_nx  = '0;
                type_nx = (DATA_IN == SDP);
              end
              default: begin
                err_nx   = 1'b1;
                state_nx = ST_IDLE;
              end
            endcase
          end
        end
        ST_SKPCHK: begin
          if (DATA_IN == SKP) begin
            skp_inc_s = 1'b1;
            if (skp_done_s) begin
              skp_os_nx = 1'b1;
              state_nx  = ST_IDLE;
            end else begin
              state_nx = ST_SKPCHK;
            end
          end else begin
            idle_eval_s = 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase

      // A non-SKP byte leaving SKPCHK is judged exactly as IDLE would judge it
      if (idle_eval_s) begin
        case (DATA_IN)
          STP, SDP: begin
            state_nx = ST_PKT;
            len_nx   = '0;
            type_nx  = (DATA_IN == SDP);
          end
          COM: begin
            state_nx  = ST_SKPCHK;
            skp_clr_s = 1'b1;
          end
          END, EDB: begin
            err_nx   = 1'b1;
            state_nx = ST_IDLE;
          end
          default: state_nx = ST_IDLE;
        endcase
      end else begin
        skp_clr_s = skp_clr_s;
      end
    end else begin
      state_nx = state_r;
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK_2MHz or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      len_r     <= '0;
      type_r    <= 1'b0;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      sop_r     <= 1'b0;
      done_r    <= 1'b0;
      abort_r   <= 1'b0;
      len_out_r <= '0;
      skp_os_r  <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nx;
      len_r     <= len_nx;
      type_r    <= type_nx;
      data_r    <= data_nx;
      valid_r   <= valid_nx;
      sop_r     <= sop_nx;
      done_r    <= done_nx;
      abort_r   <= abort_nx;
      len_out_r <= len_out_nx;
      skp_os_r  <= skp_os_nx;
      err_r     <= err_nx;
    end
  end

  assign PKT_DATA  = data_r;
  assign PKT_VALID = valid_r;
  assign PKT_SOP   = sop_r;
  assign PKT_TYPE  = type_r;
  assign PKT_DONE  = done_r;
  assign PKT_ABORT = abort_r;
  assign PKT_LEN   = len_out_r;
  assign SKP_OS    = skp_os_r;
  assign ERR       = err_r;

`ifdef PCIE_DEFRAMER_STATS_EN
  logic [15:0] pkt_cnt_r, abort_cnt_r, err_cnt_r;

  // Saturating event counters, stepped together with their pulse outputs
  always_ff @(posedge CLK_2MHz or negedge reset) begin
    if (!reset) begin
      pkt_cnt_r   <= 16'h0000;
      abort_cnt_r <= 16'h0000;
      err_cnt_r   <= 16'h0000;
    end else begin
      pkt_cnt_r   <= (done_nx  && pkt_cnt_r   != 16'hFFFF) ? pkt_cnt_r   + 16'h0001 : pkt_cnt_r;
      abort_cnt_r <= (abort_nx && abort_cnt_r != 16'hFFFF) ? abort_cnt_r + 16'h0001 : abort_cnt_r;
      err_cnt_r   <= (err_nx   && err_cnt_r   != 16'hFFFF) ? err_cnt_r   + 16'h0001 : err_cnt_r;
    end
  end

  assign PKT_CNT   = pkt_cnt_r;
  assign ABORT_CNT = abort_cnt_r;
  assign ERR_CNT   = err_cnt_r;
`endif

endmodule
